// File: rtl/logic_seq.sv
// -----------------------------------------------------------------------------
// logic_seq
//
// Multi-cycle sequencer around the ALU's 24-bit single-pass logic unit.
// Bitwise operations take one pass through the logic unit. Shift and rotate
// operations feed the logic unit output back into its in1 input once per
// clock, because one pass only moves the data by one bit. The final value is
// returned as a registered result together with N/Z/C flags.
//
// Ports
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   start    in   request, sampled only while idle
//   op       in   [2:0]  0-3 bitwise/NOT, 4 LSR, 5 ROR, 6 LSL, 7 ROL
//   count    in   [CNT_W-1:0] shift amount, ignored for op 0-3
//   in1      in   [WIDTH-1:0] operand 1
//   in2      in   [WIDTH-1:0] operand 2
//   lu_c     out  [2:0]       logic unit control (latched op)
//   lu_in1   out  [WIDTH-1:0] logic unit in1 (working value)
//   lu_in2   out  [WIDTH-1:0] logic unit in2 (latched operand 2)
//   lu_out   in   [WIDTH-1:0] logic unit output, combinational
//   busy     out  high whenever the sequencer is not idle
//   done     out  one-cycle pulse, result and flags valid from this cycle
//   result   out  [WIDTH-1:0] registered result, held until the next done
//   flag_n   out  result MSB
//   flag_z   out  result is zero
//   flag_c   out  last bit shifted out, 0 for op 0-3
// -----------------------------------------------------------------------------
module logic_seq #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [2:0]       lu_c,
    output logic [WIDTH-1:0] lu_in1,
    output logic [WIDTH-1:0] lu_in2,
    input  logic [WIDTH-1:0] lu_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_in2;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_flag_n;
    logic             r_flag_z;
    logic             r_flag_c;

    logic             w_carry_cand;

    // Bit that falls off the end during the pass currently in flight:
    // right shifts lose bit 0, left shifts lose the MSB.
    always_comb begin
        w_carry_cand = 1'b0;
        case (r_op)
            3'd4, 3'd5: w_carry_cand = r_work[0];
            3'd6, 3'd7: w_carry_cand = r_work[WIDTH-1];
            default:    w_carry_cand = 1'b0;
        endcase
    end

    // NOTE: all state here is written with non-blocking assignments so every
    // register samples the values from before the edge; lu_out in the RUN
    // branch and the carry candidate both depend on the old r_work.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_work   <= '0;
            r_in2    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_work <= in1;
                        r_in2  <= in2;
                        if (!op[2]) begin
                            // Bitwise ops need exactly one pass.
                            r_rem   <= CNT_W'(1);
                            r_state <= S_RUN;
                        end else if (count == '0) begin
                            // Zero-length shift: nothing to iterate, the
                            // operand is the answer and nothing was shifted out.
                            r_rem    <= '0;
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= in1;
                            r_flag_n <= in1[WIDTH-1];
                            r_flag_z <= (in1 == '0);
                            r_flag_c <= 1'b0;
                        end else begin
                            r_rem   <= count;
                            r_state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    r_work <= lu_out;
                    r_rem  <= r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= lu_out;
                        r_flag_n <= lu_out[WIDTH-1];
                        r_flag_z <= (lu_out == '0);
                        r_flag_c <= w_carry_cand;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Logic unit inputs come straight from registers so the combinational
    // loop through the external logic unit is always broken by a flop.
    assign lu_c   = r_op;
    assign lu_in1 = r_work;
    assign lu_in2 = r_in2;

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign result = r_result;
    assign flag_n = r_flag_n;
    assign flag_z = r_flag_z;
    assign flag_c = r_flag_c;

endmodule

// File: tb/tb_logic_seq.sv
// -----------------------------------------------------------------------------
// tb_logic_seq
//
// Self-checking bench for logic_seq. Models the external logic unit as a
// single-pass combinational block and compares every finished operation with
// a closed-form reference (whole shifts/rotates computed in one step).
// -----------------------------------------------------------------------------
module tb_logic_seq;

    localparam int WIDTH = 24;
    localparam int CNT_W = 5;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       lu_c;
    logic [WIDTH-1:0] lu_in1;
    logic [WIDTH-1:0] lu_in2;
    logic [WIDTH-1:0] lu_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;

    int n_cmp  = 0;
    int n_fail = 0;

    logic_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .count   (count),
        .in1     (in1),
        .in2     (in2),
        .lu_c    (lu_c),
        .lu_in1  (lu_in1),
        .lu_in2  (lu_in2),
        .lu_out  (lu_out),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flag_n  (flag_n),
        .flag_z  (flag_z),
        .flag_c  (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-pass logic unit: bitwise ops, or a one-bit shift/rotate of in1.
    always_comb begin
        case (lu_c)
            3'd0:    lu_out = lu_in1 | lu_in2;
            3'd1:    lu_out = lu_in1 ^ lu_in2;
            3'd2:    lu_out = lu_in1 & lu_in2;
            3'd3:    lu_out = ~lu_in1;
            3'd4:    lu_out = {1'b0, lu_in1[WIDTH-1:1]};
            3'd5:    lu_out = {lu_in1[0], lu_in1[WIDTH-1:1]};
            3'd6:    lu_out = {lu_in1[WIDTH-2:0], 1'b0};
            default: lu_out = {lu_in1[WIDTH-2:0], lu_in1[WIDTH-1]};
        endcase
    end

    // Reference: whole operation in one step. Returns {carry, result}.
    function automatic logic [WIDTH:0] ref_model(input logic [2:0] o, input int cnt,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   res;
        logic               c;
        int                 k;
        dbl = {a, a};
        res = a;
        c   = 1'b0;
        k   = cnt % WIDTH;
        case (o)
            3'd0: res = a | b;
            3'd1: res = a ^ b;
            3'd2: res = a & b;
            3'd3: res = ~a;
            3'd4: begin
                if (cnt > WIDTH)      res = '0;
                else if (cnt > 0) begin res = a >> cnt; c = a[cnt-1]; end
            end
            3'd5: begin
                dbl = dbl >> k;
                res = dbl[WIDTH-1:0];
                if (cnt > 0) c = a[(cnt-1) % WIDTH];
            end
            3'd6: begin
                if (cnt > WIDTH)      res = '0;
                else if (cnt > 0) begin res = a << cnt; c = a[WIDTH-cnt]; end
            end
            default: begin
                dbl = dbl << k;
                res = dbl[2*WIDTH-1:WIDTH];
                if (cnt > 0) c = a[WIDTH-1-((cnt-1) % WIDTH)];
            end
        endcase
        return {c, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency, busy span, result, flags and the
    // single-cycle done pulse. Operands are scrambled after acceptance.
    // With pulse_again set, a second start is raised while busy and must be
    // ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input int cnt,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit pulse_again);
        logic [WIDTH:0] exp;
        int n_exp;
        int seen;
        int busy_cycles;
        int extra_done;
        exp         = ref_model(o, cnt, a, b);
        n_exp       = o[2] ? cnt : 1;
        seen        = -1;
        busy_cycles = 0;
        extra_done  = 0;
        op    = o;
        count = CNT_W'(cnt);
        in1   = a;
        in2   = b;
        start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                op    = 3'($urandom);
                count = CNT_W'($urandom);
                in1   = WIDTH'($urandom);
                in2   = WIDTH'($urandom);
            end
            if (pulse_again && cyc == 3) start = 1'b1;
            if (pulse_again && cyc == 4) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                seen = cyc;
                break;
            end
        end
        check({tag, " latency"}, 32'(seen), 32'(n_exp + 1));
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(n_exp + 1));
        check({tag, " result"}, 32'(result), 32'(exp[WIDTH-1:0]));
        check({tag, " flag_n"}, 32'(flag_n), 32'(exp[WIDTH-1]));
        check({tag, " flag_z"}, 32'(flag_z), 32'(exp[WIDTH-1:0] == '0));
        check({tag, " flag_c"}, 32'(flag_c), 32'(exp[WIDTH]));
        check({tag, " lu_c"}, 32'(lu_c), 32'(o));
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
        check({tag, " result_hold"}, 32'(result), 32'(exp[WIDTH-1:0]));
        if (pulse_again) begin
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done) extra_done++;
            end
            check({tag, " ignored_start"}, 32'(extra_done), 32'd0);
        end
    endtask

    initial begin
        int abort_done;
        logic [2:0]       r_o;
        int               r_cnt;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;

        reset_n = 1'b0;
        start   = 1'b1;
        op      = 3'd1;
        count   = '0;
        in1     = 24'h5A5A5A;
        in2     = 24'h00FF00;

        // Reset held for two edges with start asserted.
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", {29'd0, flag_n, flag_z, flag_c}, 32'd0);
        reset_n = 1'b1;
        start   = 1'b0;

        run_op("eor",       3'd1, 4,  24'hF0F0F0, 24'h0FF00F, 1'b0);
        run_op("lsr4",      3'd4, 4,  24'h800001, 24'h000000, 1'b0);
        run_op("lsr1",      3'd4, 1,  24'h800001, 24'h000000, 1'b0);
        run_op("lsl0",      3'd6, 0,  24'hABCDEF, 24'h000000, 1'b0);
        run_op("and_zero",  3'd2, 9,  24'hFF0000, 24'h00FFFF, 1'b0);
        run_op("lsl24",     3'd6, 24, 24'hFFFFFF, 24'h000000, 1'b0);
        run_op("lsr31",     3'd4, 31, 24'hFFFFFF, 24'h000000, 1'b0);
        run_op("ror25",     3'd5, 25, 24'h000003, 24'h000000, 1'b0);
        run_op("rol_wrap",  3'd7, 24, 24'h123456, 24'h000000, 1'b1);

        // Abort: reset lands on the fourth edge after acceptance.
        op    = 3'd5;
        count = CNT_W'(10);
        in1   = 24'hC0FFEE;
        in2   = 24'h0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort flags", {29'd0, flag_n, flag_z, flag_c}, 32'd0);
        reset_n = 1'b1;
        abort_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) abort_done++;
        end
        check("abort no_done", 32'(abort_done), 32'd0);

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            r_o   = 3'($urandom);
            r_cnt = int'($urandom_range(0, 31));
            r_a   = WIDTH'($urandom);
            r_b   = WIDTH'($urandom);
            if (($urandom % 8) == 0) r_a = '0;
            run_op($sformatf("rand%0d_op%0d_n%0d", i, r_o, r_cnt), r_o, r_cnt, r_a, r_b, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_seq.md
Name: logic_seq

Overview:
- Multi-cycle sequencer wrapped around the 24-bit single-pass logic unit in the ALU.
- It registers the operands and drives the logic unit's control and data inputs.
- For bitwise ops it captures the logic unit output once.
- For shift/rotate ops it feeds the output back as in1 once per clock to get an N-bit shift, since the logic unit only shifts by one bit per pass.
- It returns a registered result plus N/Z/C flags to the ALU writeback path.

Parameters:
- WIDTH, 24, data width; fixed to the data bus width, other values unsupported.
- CNT_W, 5, width of the shift-count input; counts 0..31.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  logic op code, passed unchanged to the logic unit. 0-3 are bitwise/NOT; 4 LSR, 5 ROR, 6 LSL, 7 ROL.
- count  input  CNT_W  shift amount; ignored for op 0-3.
- in1  input  WIDTH  operand 1.
- in2  input  WIDTH  operand 2.
- lu_c  output  3  to logic unit c.
- lu_in1  output  WIDTH  to logic unit in1.
- lu_in2  output  WIDTH  to logic unit in2.
- lu_out  input  WIDTH  from logic unit out (combinational).
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  registered result; held until the next done.
- flag_n  output  1  result[WIDTH-1].
- flag_z  output  1  result == 0.
- flag_c  output  1  last bit shifted out; 0 for op 0-3.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low (reset_n); the polarity and synchronicity are fixed.
- Reset (reset_n low at a clk edge): state=IDLE, busy=0, done=0, result=0, flag_n=0, flag_z=0, flag_c=0. All internal registers are cleared.
- Reset mid-operation aborts the operation. No done pulse is produced for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge T:
  - Latch op into op_r, in1 into work, in2 into in2_r.
  - Remaining-count rem is 1 for op 0-3, and count for op 4-7.
  - If rem=0 (shift with count=0), go to DONE. Otherwise go to RUN.
- RUN, each edge:
  - Capture work <= lu_out and rem <= rem-1.
  - Also capture the carry candidate from the pre-shift work value: bit 0 for op 4/5, bit WIDTH-1 for op 6/7, 0 for op 0-3.
  - When rem goes 1 -> 0, go to DONE.
- Data path: lu_c=op_r, lu_in1=work, lu_in2=in2_r, all registered values. Outputs hold their last values in IDLE.
- DONE, one cycle:
  - done=1.
  - result = work, with flags computed from work; count=0 gives result=in1 and flag_c=0.
  - Next edge goes to IDLE.
  - result and flags are registered on the transition into DONE.
- Latency: done is high in cycle T+1+N.
  - N=1 for op 0-3.
  - N=count for op 4-7; count=0 gives done at T+1.
- Minimum issue interval is N+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued.
- count > WIDTH is legal: the sequencer simply iterates, so ROR/ROL by 24 returns the original value and LSR/LSL by 24 or more return 0.
- Input changes on in1/in2/op/count after T do not affect the operation in progress.

Test Plan:
- Reset: hold reset_n=0 two cycles with start=1 -> busy=0, done=0, result=0, all flags 0. The first start after release is accepted normally.
- EOR: op=1, in1=0xF0F0F0, in2=0x0FF00F, start at T -> done at T+2, result=0xFF00FF, flag_n=1, flag_z=0, flag_c=0.
- LSR: op=4, count=4, in1=0x800001 -> done at T+5, result=0x080000, flag_c=0, flag_z=0. With count=1 -> result=0x400000, flag_c=1.
- ROL full wrap: op=7, count=24, in1=0x123456 -> busy for 25 cycles, done at T+25, result=0x123456, flag_c=0. A start pulsed at T+3 is ignored (no second done).
- Zero count and zero flag:
  - op=6, count=0, in1=0xABCDEF -> done at T+1, result=0xABCDEF, flag_c=0.
  - op=2 (AND), in1=0xFF0000, in2=0x00FFFF -> result=0, flag_z=1.
- Abort: op=5, count=10 started, reset_n=0 at T+4 -> busy=0 and result=0 next cycle, no done in the following 20 cycles.
